// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the framed serial-in/parallel-out deserialiser.
package sipo_pkg;

    localparam bit SIPO_MSB_FIRST = 1'b1;
    localparam bit SIPO_LSB_FIRST = 1'b0;

    // Counter width able to hold 0..nbits (nbits marks a parked frame).
    function automatic int unsigned cnt_w(input int unsigned nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/aidan_mcnay_sipo_outbuf.sv
// Output word register with valid/ready handshake; loads only when the slot is free.
module aidan_mcnay_sipo_outbuf
    import sipo_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NBITS-1:0] load_data,
    input  logic             out_rdy,
    output logic             out_val,
    output logic [NBITS-1:0] data_out,
    output logic             free_c
);

    assign free_c = ~out_val | out_rdy;

    // Load wins over take so a same-cycle handoff keeps out_val high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val  <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            out_val  <= 1'b1;
            data_out <= load_data;
        end else if (out_val && out_rdy) begin
            out_val  <= 1'b0;
        end
    end

endmodule

// File: rtl/aidan_mcnay_sipo_framed.sv
// Serial-in/parallel-out deserialiser: shifts NBITS bits into a frame, parks a
// finished frame while the output word is still pending, and hands it off via val/rdy.
module aidan_mcnay_sipo_framed
    import sipo_pkg::*;
#(
    parameter int unsigned NBITS     = 32,
    parameter bit          MSB_FIRST = SIPO_MSB_FIRST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic                       data_in,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [NBITS-1:0]           data_out,
    output logic [cnt_w(NBITS)-1:0]    bit_cnt
);

    localparam int unsigned CW       = cnt_w(NBITS);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    logic [NBITS-1:0] sr;
    logic [NBITS-1:0] sr_nxt;
    logic [NBITS-1:0] shifted_c;
    logic [NBITS-1:0] load_data_c;
    logic [CW-1:0]    cnt_nxt;
    logic             acc_c;
    logic             load_c;
    logic             free_c;

    assign in_rdy = (bit_cnt < CNT_FULL);
    assign acc_c  = in_val & in_rdy & ~clear;

    assign shifted_c = (MSB_FIRST == SIPO_MSB_FIRST) ? {sr[NBITS-2:0], data_in}
                                                     : {data_in, sr[NBITS-1:1]};

    // Next-state: clear beats everything, then a parked frame, then a new bit.
    always_comb begin
        sr_nxt      = sr;
        cnt_nxt     = bit_cnt;
        load_c      = 1'b0;
        load_data_c = shifted_c;
        if (clear) begin
            sr_nxt  = '0;
            cnt_nxt = '0;
        end else if (bit_cnt == CNT_FULL) begin
            if (free_c) begin
                load_c      = 1'b1;
                load_data_c = sr;
                cnt_nxt     = '0;
            end
        end else if (acc_c) begin
            sr_nxt = shifted_c;
            if (bit_cnt == CNT_LAST) begin
                if (free_c) begin
                    load_c  = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = CNT_FULL;
                end
            end else begin
                cnt_nxt = bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= sr_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    aidan_mcnay_sipo_outbuf #(
        .NBITS (NBITS)
    ) u_outbuf (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .load_data (load_data_c),
        .out_rdy   (out_rdy),
        .out_val   (out_val),
        .data_out  (data_out),
        .free_c    (free_c)
    );

endmodule

// File: tb/tb_aidan_mcnay_sipo_framed.sv
// Bench for the framed deserialiser: an MSB-first and an LSB-first instance share stimulus.
module tb_aidan_mcnay_sipo_framed;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          in_val = 1'b0;
    logic          data_in = 1'b0;
    logic          out_rdy = 1'b0;
    logic          m_in_rdy, l_in_rdy, m_out_val, l_out_val;
    logic [N-1:0]  m_data, l_data;
    logic [CW-1:0] m_cnt, l_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aidan_mcnay_sipo_framed #(.NBITS(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .clear(clear), .in_val(in_val), .in_rdy(m_in_rdy),
        .data_in(data_in), .out_val(m_out_val), .out_rdy(out_rdy),
        .data_out(m_data), .bit_cnt(m_cnt));

    aidan_mcnay_sipo_framed #(.NBITS(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .clear(clear), .in_val(in_val), .in_rdy(l_in_rdy),
        .data_in(data_in), .out_val(l_out_val), .out_rdy(out_rdy),
        .data_out(l_data), .bit_cnt(l_cnt));

    // Stream word s is sent s[7] first; an LSB-first receiver sees it bit-reversed.
    function automatic logic [N-1:0] rev(input logic [N-1:0] s);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = s[N-1-k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (m_out_val !== 1'b0) begin n_bad++; $display("FAIL rst_out_val got %b want 0", m_out_val); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", m_data); end
        n_cmp++; if (m_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", m_cnt); end
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        n_cmp++; if (m_in_rdy !== 1'b1 || l_in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_in_rdy got %b/%b want 1", m_in_rdy, l_in_rdy); end
    endtask

    // Fixed 1,1,0,0,0,0,0,0 stream into both bit orders with a ready consumer.
    task automatic test_stream();
        logic [N-1:0] s = 8'b1100_0000;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_val = 1'b1; data_in = s[N-1-i];
            tick();
            if (i < N - 1) begin
                n_cmp++; if (m_out_val !== 1'b0 || m_cnt !== CW'(i + 1)) begin n_bad++; $display("FAIL stream_partial bit %0d got val=%b cnt=%0d want 0/%0d", i, m_out_val, m_cnt, i + 1); end
            end
        end
        in_val = 1'b0;
        n_cmp++; if (m_out_val !== 1'b1 || m_data !== 8'hC0) begin n_bad++; $display("FAIL stream_msb got %b/%h want 1/c0", m_out_val, m_data); end
        n_cmp++; if (l_out_val !== 1'b1 || l_data !== 8'h03) begin n_bad++; $display("FAIL stream_lsb got %b/%h want 1/03", l_out_val, l_data); end
        n_cmp++; if (m_cnt !== 4'd0) begin n_bad++; $display("FAIL stream_cnt got %0d want 0", m_cnt); end
        tick();
        n_cmp++; if (m_out_val !== 1'b0 || m_data !== 8'hC0) begin n_bad++; $display("FAIL stream_taken got %b/%h want 0/c0", m_out_val, m_data); end
    endtask

    // Two frames against a stalled consumer: second frame parks until out_rdy.
    task automatic test_backpressure();
        logic [2*N-1:0] s = 16'hA5_3C;
        out_rdy = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            in_val = 1'b1; data_in = s[2*N-1-i];
            tick();
        end
        tick();
        in_val = 1'b0;
        n_cmp++; if (m_out_val !== 1'b1 || m_data !== 8'hA5 || l_data !== rev(8'hA5)) begin n_bad++; $display("FAIL bp_hold got %b/%h/%h want 1/a5/%h", m_out_val, m_data, l_data, rev(8'hA5)); end
        n_cmp++; if (m_cnt !== 4'd8 || m_in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_parked got cnt=%0d rdy=%b want 8/0", m_cnt, m_in_rdy); end
        out_rdy = 1'b1;
        tick();
        n_cmp++; if (m_out_val !== 1'b1 || m_data !== 8'h3C || l_data !== rev(8'h3C)) begin n_bad++; $display("FAIL bp_second got %b/%h/%h want 1/3c/%h", m_out_val, m_data, l_data, rev(8'h3C)); end
        n_cmp++; if (m_cnt !== 4'd0 || m_in_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_release got cnt=%0d rdy=%b want 0/1", m_cnt, m_in_rdy); end
        tick();
        n_cmp++; if (m_out_val !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", m_out_val); end
    endtask

    // Clear drops a partial frame, and separately discards a parked frame.
    task automatic test_clear();
        logic [N-1:0] w0;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_val = 1'b1; data_in = 1'($urandom_range(1)); tick();
        end
        clear = 1'b1; data_in = 1'b1; tick();
        clear = 1'b0;
        n_cmp++; if (m_cnt !== 4'd0 || m_out_val !== 1'b0) begin n_bad++; $display("FAIL clr_partial got cnt=%0d val=%b want 0/0", m_cnt, m_out_val); end
        for (int i = 0; i < N; i++) begin
            data_in = w0_bit(8'h5A, i); tick();
            if (i < N - 1) begin
                n_cmp++; if (m_out_val !== 1'b0) begin n_bad++; $display("FAIL clr_early bit %0d got val=1 want 0", i); end
            end
        end
        in_val = 1'b0;
        n_cmp++; if (m_data !== 8'h5A || l_data !== rev(8'h5A) || m_out_val !== 1'b1) begin n_bad++; $display("FAIL clr_frame got %h/%h/%b want 5a/%h/1", m_data, l_data, m_out_val, rev(8'h5A)); end
        tick();
        w0 = 8'($urandom);
        out_rdy = 1'b0;
        in_val = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            data_in = (i < N) ? w0_bit(w0, i) : 1'($urandom_range(1)); tick();
        end
        in_val = 1'b0; clear = 1'b1; tick();
        clear = 1'b0;
        n_cmp++; if (m_cnt !== 4'd0 || m_out_val !== 1'b1 || m_data !== w0) begin n_bad++; $display("FAIL clr_parked got cnt=%0d val=%b data=%h want 0/1/%h", m_cnt, m_out_val, m_data, w0); end
        out_rdy = 1'b1; tick();
        n_cmp++; if (m_out_val !== 1'b0 || l_out_val !== 1'b0) begin n_bad++; $display("FAIL clr_noreload got %b/%b want 0/0", m_out_val, l_out_val); end
    endtask

    function automatic logic w0_bit(input logic [N-1:0] w, input int i);
        return w[N-1-i];
    endfunction

    // Asynchronous reset mid-frame with a word pending, then a clean frame.
    task automatic test_reset_mid();
        logic [N-1:0] w = 8'($urandom);
        out_rdy = 1'b0; in_val = 1'b1;
        for (int i = 0; i < N + 5; i++) begin
            data_in = 1'($urandom_range(1)); tick();
        end
        in_val = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (m_out_val !== 1'b0 || m_cnt !== 4'd0 || m_data !== 8'h00) begin n_bad++; $display("FAIL rstmid got val=%b cnt=%0d data=%h want 0/0/00", m_out_val, m_cnt, m_data); end
        #3 reset = 1'b0;
        tick();
        out_rdy = 1'b1; in_val = 1'b1;
        for (int i = 0; i < N; i++) begin
            data_in = w0_bit(w, i); tick();
        end
        in_val = 1'b0;
        n_cmp++; if (m_out_val !== 1'b1 || m_data !== w || l_data !== rev(w)) begin n_bad++; $display("FAIL rstmid_frame got %b/%h/%h want 1/%h/%h", m_out_val, m_data, l_data, w, rev(w)); end
        tick();
    endtask

    // Four random frames at full rate; one word per N cycles, no bubbles.
    task automatic test_back_to_back();
        logic         bits [4*N];
        logic [N-1:0] exp_m [4];
        logic [N-1:0] exp_l [4];
        int           seen = 0;
        logic         want_val;
        for (int c = 0; c < 4 * N; c++) bits[c] = 1'($urandom_range(1));
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) begin
                exp_m[f][N-1-k] = bits[f*N + k];
                exp_l[f][k]     = bits[f*N + k];
            end
        out_rdy = 1'b1;
        for (int c = 0; c < 4 * N; c++) begin
            n_cmp++; if (m_in_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_bubble cycle %0d got rdy=0 want 1", c); end
            in_val = 1'b1; data_in = bits[c];
            tick();
            want_val = ((c + 1) % N == 0);
            n_cmp++; if (m_out_val !== want_val || l_out_val !== want_val) begin n_bad++; $display("FAIL b2b_val cycle %0d got %b/%b want %b", c, m_out_val, l_out_val, want_val); end
            if (want_val && m_out_val === 1'b1) begin
                n_cmp++; if (m_data !== exp_m[seen] || l_data !== exp_l[seen]) begin n_bad++; $display("FAIL b2b_word %0d got %h/%h want %h/%h", seen, m_data, l_data, exp_m[seen], exp_l[seen]); end
                seen++;
            end
        end
        in_val = 1'b0;
        tick();
        n_cmp++; if (seen !== 4) begin n_bad++; $display("FAIL b2b_count got %0d want 4", seen); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
